// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared state encoding and constants for the vectored interrupt controller
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RUN,
        S_RETURN
    } state_e;

    localparam logic [6:0] OPC_URET = 7'h73;
    localparam int         CNT_W    = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest request index wins
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant
);

    // isolate the lowest set bit; the downward scan leaves the smallest index last
    always_comb begin
        valid = |req;
        grant = req & (~req + N'(1));
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
    end

endmodule

// File: rtl/irq_ctrl_vec.sv
// irq_ctrl_vec: edge-detected, masked, fixed-priority vectored interrupt controller with pipeline drain
module irq_ctrl_vec
    import irq_ctrl_pkg::*;
#(
    parameter int              N_SRC      = 4,
    parameter int              PC_W       = 12,
    parameter int              DRAIN_CYC  = 3,
    parameter int              RET_CYC    = 2,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'('h000),
    parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'('h010),
    localparam int             ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_SRC-1:0] irq_n,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic [PC_W-1:0]  pc,
    input  logic [6:0]       if_opcode,
    input  logic             if_clk_en,
    input  logic             pc_redirect,
    output logic             isr_stall,
    output logic             sel_isr,
    output logic             ret_isr,
    output logic             isr_running,
    output logic [PC_W-1:0]  isr_vec,
    output logic [ID_W-1:0]  isr_id,
    output logic [PC_W-1:0]  save_pc,
    output logic [N_SRC-1:0] irq_ack
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SRC-1:0]   prev_q, pending_q, pending_d, ack_q, ack_d, clr;
    logic               sel_q, sel_d, ret_q, ret_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [PC_W-1:0]    save_q, save_d;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [N_SRC-1:0]   win_grant;
    logic               is_uret;

    assign is_uret = if_opcode == OPC_URET;

    irq_prio_enc #(.N(N_SRC), .W(ID_W)) u_prio (
        .req   (pending_q & irq_mask),
        .valid (win_valid),
        .idx   (win_idx),
        .grant (win_grant)
    );

    // FSM next state: counters compare before increment so DRAIN lasts DRAIN_CYC-1 enabled cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ret_d   = ret_q;
        id_d    = id_q;
        save_d  = save_q;
        ack_d   = '0;
        clr     = '0;
        case (state_q)
            S_IDLE: if (win_valid) begin
                state_d = S_DRAIN;
                id_d    = win_idx;
                clr     = win_grant;
                ack_d   = win_grant;
                save_d  = pc;
                cnt_d   = CNT_W'(1);
            end
            S_DRAIN: begin
                if (pc_redirect) save_d = pc;
                if (if_clk_en) begin
                    if (cnt_q >= CNT_W'(DRAIN_CYC - 1)) begin
                        state_d = S_RUN;
                        sel_d   = 1'b1;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: if (is_uret) begin
                state_d = S_RETURN;
                sel_d   = 1'b0;
                ret_d   = 1'b1;
                cnt_d   = CNT_W'(1);
            end
            default: if (if_clk_en) begin
                if (cnt_q >= CNT_W'(RET_CYC - 1)) begin
                    state_d = S_IDLE;
                    ret_d   = 1'b0;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
        endcase
        pending_d = (pending_q & ~clr) | (prev_q & ~irq_n);
    end

    // state registers; reset drops any pending edges and idles every output
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prev_q    <= '1;
            pending_q <= '0;
            ack_q     <= '0;
            sel_q     <= 1'b0;
            ret_q     <= 1'b0;
            id_q      <= '0;
            save_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= irq_n;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            sel_q     <= sel_d;
            ret_q     <= ret_d;
            id_q      <= id_d;
            save_q    <= save_d;
        end
    end

    assign isr_stall   = state_q == S_DRAIN || state_q == S_RETURN || (state_q == S_RUN && is_uret);
    assign isr_running = state_q != S_IDLE;
    assign isr_vec     = PC_W'(VEC_BASE + PC_W'(id_q) * VEC_STRIDE);
    assign sel_isr     = sel_q;
    assign ret_isr     = ret_q;
    assign isr_id      = id_q;
    assign save_pc     = save_q;
    assign irq_ack     = ack_q;

endmodule

// File: tb/tb_irq_ctrl_vec.sv
// tb_irq_ctrl_vec: scoreboard bench for the vectored interrupt controller
module tb_irq_ctrl_vec;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  irq_n, irq_mask, irq_ack;
    logic [11:0] pc, isr_vec, save_pc;
    logic [6:0]  if_opcode;
    logic        if_clk_en, pc_redirect;
    logic        isr_stall, sel_isr, ret_isr, isr_running;
    logic [1:0]  isr_id;

    typedef struct packed {
        logic [3:0]  ack;
        logic [11:0] vec;
        logic [11:0] spc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl_vec dut (
        .clk         (clk),
        .nrst        (nrst),
        .irq_n       (irq_n),
        .irq_mask    (irq_mask),
        .pc          (pc),
        .if_opcode   (if_opcode),
        .if_clk_en   (if_clk_en),
        .pc_redirect (pc_redirect),
        .isr_stall   (isr_stall),
        .sel_isr     (sel_isr),
        .ret_isr     (ret_isr),
        .isr_running (isr_running),
        .isr_vec     (isr_vec),
        .isr_id      (isr_id),
        .save_pc     (save_pc),
        .irq_ack     (irq_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [3:0] ack, input logic [11:0] vec, input logic [11:0] spc);
        sb.push_back({ack, vec, spc});
    endtask

    task automatic uret_return();
        if_opcode = 7'h73;
        #1 chk("uret_stall", isr_stall, 1);
        step(1);
        chk("ret_isr_on", ret_isr, 1);
        chk("sel_isr_off", sel_isr, 0);
        if_opcode = 7'h00;
        step(1);
        chk("ret_isr_done", ret_isr, 0);
        chk("back_idle", isr_running, 0);
    endtask

    // every acceptance pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (nrst && irq_ack != 4'b0000) begin
            if (sb.size() == 0) chk("ack_unexpected", irq_ack, 0);
            else begin
                mon_e = sb.pop_front();
                chk("ack", irq_ack, mon_e.ack);
                chk("ack_vec", isr_vec, mon_e.vec);
                chk("ack_save_pc", save_pc, mon_e.spc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; irq_n = '1; irq_mask = 4'hF; pc = '0;
        if_opcode = '0; if_clk_en = 1'b1; pc_redirect = 1'b0;
        step(2);
        chk("rst_running", isr_running, 0);
        chk("rst_sel", sel_isr, 0);
        chk("rst_ret", ret_isr, 0);
        chk("rst_stall", isr_stall, 0);
        chk("rst_ack", irq_ack, 0);
        chk("rst_save", save_pc, 0);
        chk("rst_vec", isr_vec, 0);
        nrst = 1'b1;
        step(1);
        // single source, nominal entry timing
        pc = 12'h084; irq_n = 4'b1011;
        expect_entry(4'b0100, 12'h020, 12'h084);
        step(1); chk("t1_not_yet", isr_running, 0);
        step(1); chk("t1_drain", isr_running, 1);
        chk("t1_save", save_pc, 12'h084);
        chk("t1_stall", isr_stall, 1);
        chk("t1_sel0", sel_isr, 0);
        step(1); chk("t1_sel_early", sel_isr, 0);
        step(1); chk("t1_sel", sel_isr, 1);
        chk("t1_vec", isr_vec, 12'h020);
        chk("t1_run_nostall", isr_stall, 0);
        uret_return();
        // two simultaneous edges: lower index first, other taken after return
        irq_n = '1; step(1);
        pc = 12'h200; irq_n = 4'b0101;
        expect_entry(4'b0010, 12'h010, 12'h200);
        expect_entry(4'b1000, 12'h030, 12'h300);
        step(2); chk("t2_id1", isr_id, 1);
        step(2); chk("t2_sel", sel_isr, 1);
        chk("t2_vec1", isr_vec, 12'h010);
        pc = 12'h300;
        uret_return();
        step(1); chk("t2_id3", isr_id, 3);
        chk("t2_running", isr_running, 1);
        chk("t2_save3", save_pc, 12'h300);
        step(2); chk("t2_vec3", isr_vec, 12'h030);
        chk("t2_sel3", sel_isr, 1);
        uret_return();
        // redirect recaptures during DRAIN only
        irq_n = '1; step(1);
        pc = 12'h050; irq_n = 4'b1110;
        expect_entry(4'b0001, 12'h000, 12'h050);
        step(2); chk("t3_save_entry", save_pc, 12'h050);
        pc = 12'h100; pc_redirect = 1'b1;
        step(1); chk("t3_redirect", save_pc, 12'h100);
        pc_redirect = 1'b0;
        step(1); chk("t3_sel", sel_isr, 1);
        pc = 12'h1FF; pc_redirect = 1'b1;
        step(1); chk("t3_run_frozen", save_pc, 12'h100);
        pc_redirect = 1'b0;
        uret_return();
        // fetch hold in DRAIN delays sel_isr by the hold length
        irq_n = '1; step(1);
        pc = 12'h0A0; irq_n = 4'b1011;
        expect_entry(4'b0100, 12'h020, 12'h0A0);
        step(3);
        if_clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t4_held_sel", sel_isr, 0);
            chk("t4_held_run", isr_running, 1);
        end
        if_clk_en = 1'b1;
        step(1); chk("t4_sel", sel_isr, 1);
        uret_return();
        // masked source waits; URET in IDLE is ignored; unmask enters next cycle
        irq_n = '1; irq_mask = 4'b1110; step(1);
        irq_n = 4'b1110; if_opcode = 7'h73;
        step(4); chk("t5_masked", isr_running, 0);
        chk("t5_no_ret", ret_isr, 0);
        chk("t5_idle_nostall", isr_stall, 0);
        if_opcode = 7'h00; irq_mask = 4'hF;
        expect_entry(4'b0001, 12'h000, 12'h0A0);
        step(1); chk("t5_unmask", isr_running, 1);
        step(2); chk("t5_sel", sel_isr, 1);
        // asynchronous reset mid-RUN drops everything including pending edges
        irq_n = 4'b0110; step(1);
        #3 nrst = 1'b0;
        #1 chk("t6_running", isr_running, 0);
        chk("t6_sel", sel_isr, 0);
        chk("t6_ret", ret_isr, 0);
        chk("t6_stall", isr_stall, 0);
        chk("t6_save", save_pc, 0);
        chk("t6_id", isr_id, 0);
        chk("t6_vec", isr_vec, 0);
        irq_n = '1; step(2);
        nrst = 1'b1;
        step(5); chk("t6_pending_lost", isr_running, 0);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
